// File: rtl/adc_stream_qualifier_1x_pkg.sv
// ---------------------------------------------------------------------------
// adc_stream_qualifier_1x_pkg
//
// Shared definitions for the ADC stream qualifier slice:
//   - qualifier FSM state encodings (ST_IDLE, ST_SETTLE, ST_RUN)
//   - sample geometry: 16-bit samples, 2 samples per clk1x word
//   - swap_halves(): exchanges the two samples packed in one word
// ---------------------------------------------------------------------------
package adc_stream_qualifier_1x_pkg;

   localparam int SAMPLE_W = 16;
   localparam int SPC      = 2;
   localparam int WORD_W   = SAMPLE_W * SPC;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   // Exchanges S1 and S0 of a packed [S1,S0] word when swap is set.
   function automatic logic [WORD_W-1:0] swap_halves(input logic [WORD_W-1:0] word,
                                                     input logic              swap);
      logic [WORD_W-1:0] result;
      result = word;
      if (swap) begin
         result = {word[SAMPLE_W-1:0], word[WORD_W-1:SAMPLE_W]};
      end
      return result;
   endfunction

endpackage

// File: rtl/adc_stream_qualifier_1x_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//
// Generic saturating event counter with synchronous clear.
// When clear and incr arrive together the increment wins, so the count
// restarts at 1 rather than 0 and no event is lost.
//
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous, active-low reset
//   clear    in   zero the count
//   incr     in   count one event (saturates at all-ones)
//   count    out  COUNT_W registered count
// ---------------------------------------------------------------------------
module sat_counter
   import adc_stream_qualifier_1x_pkg::*;
#(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clear,
   input  logic               incr,
   output logic [COUNT_W-1:0] count
);

   localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (incr) begin
         if (clear) begin
            count_d = COUNT_W'(1);
         end else if (count_q != COUNT_MAX) begin
            count_d = count_q + COUNT_W'(1);
         end
      end else if (clear) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/adc_stream_qualifier_1x.sv
// ---------------------------------------------------------------------------
// adc_stream_qualifier_1x
//
// Sits in front of the 2x1 ADC gearbox in the clk1x domain. Raw 2 SPC I/Q
// words are held off until adc_valid_in has been continuously high for
// SETTLE_CYCLES cycles; after that, words are forwarded through one register
// stage (optionally sample-swapped) with a qualified valid and a gearbox
// enable. A valid dropout while running is an underflow: it is recorded in
// sticky/counter status and sends the FSM back to re-settle.
//
// Parameters:
//   SETTLE_CYCLES  consecutive valid cycles needed to reach RUN (>= 1)
//   COUNT_W        width of the saturating underflow counter
//
// Ports:
//   clk1x             in   sample-rate clock
//   reset_n_1x        in   asynchronous, active-low reset
//   adc_q_in          in   32  raw Q word [S1,S0]
//   adc_i_in          in   32  raw I word [S1,S0]
//   adc_valid_in      in   raw data valid
//   enable_in         in   capture enable
//   swap_samples      in   exchange S1/S0 of both I and Q
//   clear_status      in   pulse, clears underflow status
//   adc_q_out_1x      out  32  qualified Q word (0 when not valid)
//   adc_i_out_1x      out  32  qualified I word (0 when not valid)
//   valid_out_1x      out  qualified valid
//   enable_out_1x     out  gearbox enable, high while running
//   underflow_sticky  out  set by any RUN-state dropout
//   underflow_count   out  COUNT_W saturating dropout count
//   state_out         out  2   FSM state (0 IDLE, 1 SETTLE, 2 RUN)
// ---------------------------------------------------------------------------
module adc_stream_qualifier_1x
   import adc_stream_qualifier_1x_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16,
   parameter int COUNT_W       = 16
) (
   input  logic               clk1x,
   input  logic               reset_n_1x,
   input  logic [31:0]        adc_q_in,
   input  logic [31:0]        adc_i_in,
   input  logic               adc_valid_in,
   input  logic               enable_in,
   input  logic               swap_samples,
   input  logic               clear_status,
   output logic [31:0]        adc_q_out_1x,
   output logic [31:0]        adc_i_out_1x,
   output logic               valid_out_1x,
   output logic               enable_out_1x,
   output logic               underflow_sticky,
   output logic [COUNT_W-1:0] underflow_count,
   output logic [1:0]         state_out
);

   // Sized so SETTLE_CYCLES-1 is always representable; the counter is
   // cleared on reaching RUN, so it never wraps.
   localparam int                      SETTLE_CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST  = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

   state_t                  state_q,      state_d;
   logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [WORD_W-1:0]       i_data_q,     i_data_d;
   logic [WORD_W-1:0]       q_data_q,     q_data_d;
   logic                    valid_q,      valid_d;
   logic                    enable_q,     enable_d;
   logic                    sticky_q,     sticky_d;
   logic                    underflow;

   // Next-state and output logic. enable_in=0 overrides everything and
   // never counts as an underflow. Data/valid/enable are only non-zero when
   // a valid word is sampled while already in RUN, which gives the single
   // cycle latency and keeps the data outputs at zero whenever valid is low.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      i_data_d     = '0;
      q_data_d     = '0;
      valid_d      = 1'b0;
      enable_d     = 1'b0;
      underflow    = 1'b0;

      if (!enable_in) begin
         state_d      = ST_IDLE;
         settle_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d      = ST_SETTLE;
               settle_cnt_d = '0;
            end
            ST_SETTLE: begin
               if (adc_valid_in) begin
                  if (settle_cnt_q == SETTLE_LAST) begin
                     state_d      = ST_RUN;
                     settle_cnt_d = '0;
                  end else begin
                     settle_cnt_d = settle_cnt_q + SETTLE_CNT_W'(1);
                  end
               end else begin
                  settle_cnt_d = '0;
               end
            end
            ST_RUN: begin
               if (adc_valid_in) begin
                  valid_d  = 1'b1;
                  enable_d = 1'b1;
                  i_data_d = swap_halves(adc_i_in, swap_samples);
                  q_data_d = swap_halves(adc_q_in, swap_samples);
               end else begin
                  underflow    = 1'b1;
                  state_d      = ST_SETTLE;
                  settle_cnt_d = '0;
               end
            end
            default: begin
               state_d      = ST_IDLE;
               settle_cnt_d = '0;
            end
         endcase
      end

      // Underflow is applied after the clear so a coincident dropout wins.
      sticky_d = sticky_q;
      if (clear_status) begin
         sticky_d = 1'b0;
      end
      if (underflow) begin
         sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk1x or negedge reset_n_1x) begin
      if (!reset_n_1x) begin
         state_q      <= ST_IDLE;
         settle_cnt_q <= '0;
         i_data_q     <= '0;
         q_data_q     <= '0;
         valid_q      <= 1'b0;
         enable_q     <= 1'b0;
         sticky_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         i_data_q     <= i_data_d;
         q_data_q     <= q_data_d;
         valid_q      <= valid_d;
         enable_q     <= enable_d;
         sticky_q     <= sticky_d;
      end
   end

   sat_counter #(
      .COUNT_W (COUNT_W)
   ) u_underflow_counter (
      .clk     (clk1x),
      .reset_n (reset_n_1x),
      .clear   (clear_status),
      .incr    (underflow),
      .count   (underflow_count)
   );

   assign adc_i_out_1x     = i_data_q;
   assign adc_q_out_1x     = q_data_q;
   assign valid_out_1x     = valid_q;
   assign enable_out_1x    = enable_q;
   assign underflow_sticky = sticky_q;
   assign state_out        = state_q;

endmodule

// File: tb/tb_adc_stream_qualifier_1x.sv
// ---------------------------------------------------------------------------
// tb_adc_stream_qualifier_1x
//
// Bench for adc_stream_qualifier_1x. The main instance uses SETTLE_CYCLES=16
// and a 2-bit underflow counter so saturation is reachable; a second
// instance with SETTLE_CYCLES=1 shares the same stimulus. Qualified words
// expected from the main instance are queued when driven and popped by a
// negedge monitor whenever valid_out_1x is high.
// ---------------------------------------------------------------------------
module tb_adc_stream_qualifier_1x;

   logic        clk1x;
   logic        reset_n_1x;
   logic [31:0] adc_q_in;
   logic [31:0] adc_i_in;
   logic        adc_valid_in;
   logic        enable_in;
   logic        swap_samples;
   logic        clear_status;

   logic [31:0] adc_q_out_1x;
   logic [31:0] adc_i_out_1x;
   logic        valid_out_1x;
   logic        enable_out_1x;
   logic        underflow_sticky;
   logic [1:0]  underflow_count;
   logic [1:0]  state_out;

   logic [31:0] one_q_out;
   logic [31:0] one_i_out;
   logic        one_valid_out;
   logic        one_enable_out;
   logic        one_sticky;
   logic [15:0] one_count;
   logic [1:0]  one_state;

   typedef struct {
      logic [31:0] i;
      logic [31:0] q;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   adc_stream_qualifier_1x #(
      .SETTLE_CYCLES (16),
      .COUNT_W       (2)
   ) dut (
      .clk1x            (clk1x),
      .reset_n_1x       (reset_n_1x),
      .adc_q_in         (adc_q_in),
      .adc_i_in         (adc_i_in),
      .adc_valid_in     (adc_valid_in),
      .enable_in        (enable_in),
      .swap_samples     (swap_samples),
      .clear_status     (clear_status),
      .adc_q_out_1x     (adc_q_out_1x),
      .adc_i_out_1x     (adc_i_out_1x),
      .valid_out_1x     (valid_out_1x),
      .enable_out_1x    (enable_out_1x),
      .underflow_sticky (underflow_sticky),
      .underflow_count  (underflow_count),
      .state_out        (state_out)
   );

   adc_stream_qualifier_1x #(
      .SETTLE_CYCLES (1),
      .COUNT_W       (16)
   ) dut_one (
      .clk1x            (clk1x),
      .reset_n_1x       (reset_n_1x),
      .adc_q_in         (adc_q_in),
      .adc_i_in         (adc_i_in),
      .adc_valid_in     (adc_valid_in),
      .enable_in        (enable_in),
      .swap_samples     (swap_samples),
      .clear_status     (clear_status),
      .adc_q_out_1x     (one_q_out),
      .adc_i_out_1x     (one_i_out),
      .valid_out_1x     (one_valid_out),
      .enable_out_1x    (one_enable_out),
      .underflow_sticky (one_sticky),
      .underflow_count  (one_count),
      .state_out        (one_state)
   );

   // Free-running 100 MHz sample clock.
   initial clk1x = 1'b0;
   always #5 clk1x = ~clk1x;

   // Hard stop in case a scenario ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   // Scoreboard monitor: every qualified word must match the oldest queued
   // expectation, and the data outputs must be zero while valid is low.
   always @(negedge clk1x) begin
      if (reset_n_1x === 1'b1) begin
         if (valid_out_1x === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("[TB] FAIL unexpected_valid: got i=%h q=%h, required no valid word", adc_i_out_1x, adc_q_out_1x);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (adc_i_out_1x !== e.i || adc_q_out_1x !== e.q) begin
                  bad++;
                  $display("[TB] FAIL sb_data: got i=%h q=%h, required i=%h q=%h", adc_i_out_1x, adc_q_out_1x, e.i, e.q);
               end
            end
         end else begin
            total++;
            if (adc_i_out_1x !== 32'h0 || adc_q_out_1x !== 32'h0) begin
               bad++;
               $display("[TB] FAIL idle_data_zero: got i=%h q=%h, required 0", adc_i_out_1x, adc_q_out_1x);
            end
         end
      end
   end

   function automatic logic [31:0] word_i(input int k);
      return 32'hA000_0000 + 32'(k);
   endfunction

   function automatic logic [31:0] word_q(input int k);
      return 32'h5000_0000 + 32'(k * 3);
   endfunction

   // Drives one clk1x cycle of stimulus; returns 1 ns after the edge.
   task automatic applyStimulus(input logic en, input logic vld,
                                input logic [31:0] i_word, input logic [31:0] q_word,
                                input logic clr);
      enable_in    = en;
      adc_valid_in = vld;
      adc_i_in     = i_word;
      adc_q_in     = q_word;
      clear_status = clr;
      @(posedge clk1x);
      #1;
      clear_status = 1'b0;
   endtask

   task automatic test_reset();
      reset_n_1x = 1'b0;
      repeat (2) @(posedge clk1x);
      #1;
      total++;
      if ({adc_i_out_1x, adc_q_out_1x} !== 64'h0) begin
         bad++;
         $display("[TB] FAIL reset_data: got i=%h q=%h, required 0", adc_i_out_1x, adc_q_out_1x);
      end
      total++;
      if ({valid_out_1x, enable_out_1x, underflow_sticky} !== 3'b000) begin
         bad++;
         $display("[TB] FAIL reset_flags: got v/e/s=%b, required 000", {valid_out_1x, enable_out_1x, underflow_sticky});
      end
      total++;
      if (underflow_count !== 2'd0 || state_out !== 2'd0) begin
         bad++;
         $display("[TB] FAIL reset_status: got count=%0d state=%0d, required 0/0", underflow_count, state_out);
      end
      @(negedge clk1x);
      reset_n_1x = 1'b1;
      for (int n = 0; n < 3; n++) applyStimulus(1'b0, 1'b1, 32'h1, 32'h2, 1'b0);
      total++;
      if (state_out !== 2'd0) begin
         bad++;
         $display("[TB] FAIL reset_idle_hold: got state=%0d, required 0", state_out);
      end
   endtask

   task automatic test_settle();
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      total++;
      if (state_out !== 2'd1) begin
         bad++;
         $display("[TB] FAIL settle_enter: got state=%0d, required 1", state_out);
      end
      for (int k = 1; k <= 16; k++) begin
         applyStimulus(1'b1, 1'b1, word_i(k), word_q(k), 1'b0);
         if (k == 15) begin
            total++;
            if (state_out !== 2'd1) begin
               bad++;
               $display("[TB] FAIL settle_15: got state=%0d, required 1", state_out);
            end
         end
      end
      total++;
      if (state_out !== 2'd2 || valid_out_1x !== 1'b0 || enable_out_1x !== 1'b0) begin
         bad++;
         $display("[TB] FAIL settle_run: got state=%0d v=%b e=%b, required 2/0/0", state_out, valid_out_1x, enable_out_1x);
      end
      for (int k = 17; k <= 20; k++) begin
         sb.push_back('{i: word_i(k), q: word_q(k)});
         applyStimulus(1'b1, 1'b1, word_i(k), word_q(k), 1'b0);
         if (k == 17) begin
            total++;
            if (valid_out_1x !== 1'b1 || enable_out_1x !== 1'b1) begin
               bad++;
               $display("[TB] FAIL first_valid: got v=%b e=%b, required 1/1", valid_out_1x, enable_out_1x);
            end
         end
      end
   endtask

   task automatic test_underflow();
      total++;
      if (underflow_count !== 2'd0 || underflow_sticky !== 1'b0) begin
         bad++;
         $display("[TB] FAIL pre_underflow: got count=%0d sticky=%b, required 0/0", underflow_count, underflow_sticky);
      end
      applyStimulus(1'b1, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);
      total++;
      if (valid_out_1x !== 1'b0 || enable_out_1x !== 1'b0 || state_out !== 2'd1) begin
         bad++;
         $display("[TB] FAIL underflow_out: got v=%b e=%b state=%0d, required 0/0/1", valid_out_1x, enable_out_1x, state_out);
      end
      total++;
      if (underflow_sticky !== 1'b1 || underflow_count !== 2'd1) begin
         bad++;
         $display("[TB] FAIL underflow_status: got sticky=%b count=%0d, required 1/1", underflow_sticky, underflow_count);
      end
      for (int k = 30; k < 46; k++) applyStimulus(1'b1, 1'b1, word_i(k), word_q(k), 1'b0);
      total++;
      if (state_out !== 2'd2) begin
         bad++;
         $display("[TB] FAIL requalify: got state=%0d, required 2", state_out);
      end
      sb.push_back('{i: word_i(46), q: word_q(46)});
      applyStimulus(1'b1, 1'b1, word_i(46), word_q(46), 1'b0);
   endtask

   task automatic test_swap();
      swap_samples = 1'b1;
      sb.push_back('{i: 32'h1111_2222, q: 32'h3333_4444});
      applyStimulus(1'b1, 1'b1, 32'h2222_1111, 32'h4444_3333, 1'b0);
      total++;
      if (adc_i_out_1x !== 32'h1111_2222 || adc_q_out_1x !== 32'h3333_4444) begin
         bad++;
         $display("[TB] FAIL swap: got i=%h q=%h, required 11112222/33334444", adc_i_out_1x, adc_q_out_1x);
      end
      sb.push_back('{i: 32'h5678_1234, q: 32'hBEEF_DEAD});
      applyStimulus(1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
      swap_samples = 1'b0;
      sb.push_back('{i: 32'h1234_5678, q: 32'hDEAD_BEEF});
      applyStimulus(1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
   endtask

   task automatic test_interrupted_settle();
      sb.push_back('{i: word_i(50), q: word_q(50)});
      applyStimulus(1'b1, 1'b1, word_i(50), word_q(50), 1'b1);
      total++;
      if (underflow_sticky !== 1'b0 || underflow_count !== 2'd0) begin
         bad++;
         $display("[TB] FAIL clear: got sticky=%b count=%0d, required 0/0", underflow_sticky, underflow_count);
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      total++;
      if (state_out !== 2'd0 || enable_out_1x !== 1'b0 || underflow_count !== 2'd0 || underflow_sticky !== 1'b0) begin
         bad++;
         $display("[TB] FAIL disable_no_underflow: got state=%0d e=%b count=%0d sticky=%b, required 0/0/0/0", state_out, enable_out_1x, underflow_count, underflow_sticky);
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, word_i(k), word_q(k), 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
      total++;
      if (state_out !== 2'd0) begin
         bad++;
         $display("[TB] FAIL toggle_idle: got state=%0d, required 0", state_out);
      end
      applyStimulus(1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
      for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1, word_i(k), word_q(k), 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      total++;
      if (state_out !== 2'd1 || underflow_count !== 2'd0) begin
         bad++;
         $display("[TB] FAIL gap: got state=%0d count=%0d, required 1/0", state_out, underflow_count);
      end
      for (int k = 1; k <= 16; k++) begin
         applyStimulus(1'b1, 1'b1, word_i(k), word_q(k), 1'b0);
         if (k == 15) begin
            total++;
            if (state_out !== 2'd1) begin
               bad++;
               $display("[TB] FAIL gap_settle_15: got state=%0d, required 1", state_out);
            end
         end
      end
      total++;
      if (state_out !== 2'd2 || underflow_count !== 2'd0) begin
         bad++;
         $display("[TB] FAIL gap_run: got state=%0d count=%0d, required 2/0", state_out, underflow_count);
      end
      sb.push_back('{i: word_i(60), q: word_q(60)});
      applyStimulus(1'b1, 1'b1, word_i(60), word_q(60), 1'b0);
   endtask

   task automatic test_saturation();
      for (int u = 1; u <= 5; u++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
         total++;
         if (underflow_count !== 2'((u > 3) ? 3 : u) || state_out !== 2'd1) begin
            bad++;
            $display("[TB] FAIL saturate_%0d: got count=%0d state=%0d, required %0d/1", u, underflow_count, state_out, (u > 3) ? 3 : u);
         end
         for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b1, word_i(k), word_q(k), 1'b0);
      end
      total++;
      if (underflow_sticky !== 1'b1 || state_out !== 2'd2) begin
         bad++;
         $display("[TB] FAIL saturate_end: got sticky=%b state=%0d, required 1/2", underflow_sticky, state_out);
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
      total++;
      if (underflow_count !== 2'd1 || underflow_sticky !== 1'b1) begin
         bad++;
         $display("[TB] FAIL clear_vs_underflow: got count=%0d sticky=%b, required 1/1", underflow_count, underflow_sticky);
      end
      for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b1, word_i(k), word_q(k), 1'b0);
   endtask

   task automatic test_enable_drop();
      sb.push_back('{i: word_i(70), q: word_q(70)});
      applyStimulus(1'b1, 1'b1, word_i(70), word_q(70), 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      total++;
      if (state_out !== 2'd0 || valid_out_1x !== 1'b0 || underflow_count !== 2'd1 || underflow_sticky !== 1'b1) begin
         bad++;
         $display("[TB] FAIL enable_drop: got state=%0d v=%b count=%0d sticky=%b, required 0/0/1/1", state_out, valid_out_1x, underflow_count, underflow_sticky);
      end
   endtask

   task automatic test_settle_one();
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h0BAD_0BAD, 32'h0, 1'b0);
      total++;
      if (one_state !== 2'd2 || state_out !== 2'd1) begin
         bad++;
         $display("[TB] FAIL settle_one: got one_state=%0d state=%0d, required 2/1", one_state, state_out);
      end
      applyStimulus(1'b1, 1'b1, 32'h7777_8888, 32'h9999_AAAA, 1'b0);
      total++;
      if (one_valid_out !== 1'b1 || one_enable_out !== 1'b1 || one_i_out !== 32'h7777_8888 || one_q_out !== 32'h9999_AAAA) begin
         bad++;
         $display("[TB] FAIL settle_one_data: got v=%b e=%b i=%h q=%h, required 1/1/77778888/9999aaaa", one_valid_out, one_enable_out, one_i_out, one_q_out);
      end
   endtask

   task automatic test_reset_mid_run();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b1, word_i(k), word_q(k), 1'b0);
      sb.push_back('{i: word_i(80), q: word_q(80)});
      applyStimulus(1'b1, 1'b1, word_i(80), word_q(80), 1'b0);
      @(negedge clk1x);
      #1;
      reset_n_1x = 1'b0;
      #1;
      total++;
      if ({adc_i_out_1x, adc_q_out_1x} !== 64'h0 || valid_out_1x !== 1'b0 || enable_out_1x !== 1'b0) begin
         bad++;
         $display("[TB] FAIL async_reset_data: got i=%h q=%h v=%b e=%b, required 0", adc_i_out_1x, adc_q_out_1x, valid_out_1x, enable_out_1x);
      end
      total++;
      if (underflow_sticky !== 1'b0 || underflow_count !== 2'd0 || state_out !== 2'd0) begin
         bad++;
         $display("[TB] FAIL async_reset_status: got sticky=%b count=%0d state=%0d, required 0/0/0", underflow_sticky, underflow_count, state_out);
      end
      enable_in = 1'b0;
      @(negedge clk1x);
      reset_n_1x = 1'b1;
      for (int n = 0; n < 3; n++) applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
      total++;
      if (state_out !== 2'd0) begin
         bad++;
         $display("[TB] FAIL post_reset_idle: got state=%0d, required 0", state_out);
      end
      applyStimulus(1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
      total++;
      if (state_out !== 2'd1) begin
         bad++;
         $display("[TB] FAIL post_reset_enable: got state=%0d, required 1", state_out);
      end
   endtask

   initial begin
      reset_n_1x   = 1'b0;
      adc_q_in     = 32'h0;
      adc_i_in     = 32'h0;
      adc_valid_in = 1'b0;
      enable_in    = 1'b0;
      swap_samples = 1'b0;
      clear_status = 1'b0;

      test_reset();
      test_settle();
      test_underflow();
      test_swap();
      test_interrupted_settle();
      test_saturation();
      test_enable_drop();
      test_settle_one();
      test_reset_mid_run();

      @(negedge clk1x);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL sb_drain: got %0d pending words, required 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_stream_qualifier_1x.md
Name: adc_stream_qualifier_1x

Overview:
- Upstream neighbour of the 2x1 ADC gearbox. Runs entirely in the clk1x domain.
- Takes raw 2 SPC I/Q words from the RF data converter interface and holds them off until the stream has been continuously valid for a settling window.
- Then forwards registered, optionally sample-swapped data with a qualified valid and a downstream enable.
- Detects valid dropouts (underflow) while running and reports them through sticky and counter status.

Parameters:
- SETTLE_CYCLES, 16, consecutive valid input cycles required before RUN; legal range >= 1.
- COUNT_W, 16, width of the saturating underflow counter.

Ports:
- clk1x  in  1  sample-rate clock.
- reset_n_1x  in  1  asynchronous, active-low reset.
- adc_q_in  in  32  Q samples packed [S1,S0], S0 in LSBs.
- adc_i_in  in  32  I samples packed [S1,S0], S0 in LSBs.
- adc_valid_in  in  1  raw data-valid from converter interface.
- enable_in  in  1  capture enable; synchronous to clk1x.
- swap_samples  in  1  quasi-static; 1 = exchange [31:16] and [15:0] of both I and Q.
- clear_status  in  1  single-cycle pulse; clears underflow status.
- adc_q_out_1x  out  32  qualified Q data to gearbox.
- adc_i_out_1x  out  32  qualified I data to gearbox.
- valid_out_1x  out  1  qualified valid to gearbox.
- enable_out_1x  out  1  high while in RUN; drives the gearbox enable.
- underflow_sticky  out  1  set on any RUN-state dropout.
- underflow_count  out  COUNT_W  saturating dropout count.
- state_out  out  2  current FSM state: 0 IDLE, 1 SETTLE, 2 RUN.

Behaviour:
- Reset (async assert, sync release by clk1x): state IDLE, settle counter 0. All outputs 0, including data, valid, enable, sticky, count and state_out.
- All outputs are registered. Data/valid latency is exactly 1 clk1x cycle from input to output when in RUN.
- When valid_out_1x is 0, both data outputs are 32'b0.
- Swapping is applied on the input-to-output register: out[31:16] = in[15:0] and out[15:0] = in[31:16], for I and Q independently.
- FSM transitions, evaluated each cycle. enable_in=0 has highest priority in every state.
  - IDLE: enable_in=1 -> SETTLE with counter cleared.
  - SETTLE: if adc_valid_in=1, the counter increments. If adc_valid_in=0, the counter clears, with no error.
  - SETTLE -> RUN: when adc_valid_in=1 and counter == SETTLE_CYCLES-1, the next state is RUN. The first qualified sample is the first valid input sampled in RUN.
  - SETTLE_CYCLES=1 gives RUN after a single valid cycle.
  - RUN: valid_out_1x <= adc_valid_in, data registered as above. enable_out_1x <= 1 from the cycle after entering RUN.
  - RUN with adc_valid_in=0 is an underflow:
    - sticky is set and the count increments, saturating at 2^COUNT_W-1.
    - next state is SETTLE with counter cleared; valid and enable outputs go 0 next cycle.
  - Any state with enable_in=0 -> IDLE next cycle; valid/enable/data cleared next cycle. No underflow is recorded for enable deassertion, even if adc_valid_in=0 in the same cycle.
- Settle counter width: $clog2(SETTLE_CYCLES+1); it never wraps.
- clear_status zeroes sticky and count. If a clear and an underflow occur in the same cycle, the underflow wins: count=1, sticky=1.
- Status is not cleared by enable_in; only reset or clear_status clears it.
- enable_in toggled 1->0->1 mid-SETTLE restarts settling from 0.

Decomposition:
- Shared package: state encodings (ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_RUN=2'd2), the sample width constant (16), and the SPC constant (2).
- One natural sub-module: sat_counter (COUNT_W generic saturating counter with clear and increment, increment priority), used for underflow_count.

Test Plan:
- Reset mid-RUN: assert reset_n_1x=0 asynchronously -> all outputs 0 immediately; after release, state_out=0 until enable_in=1.
- Settle: SETTLE_CYCLES=16, enable_in=1, continuous valid with incrementing data -> state_out=2 after 16 valid cycles. First valid_out_1x carries the 17th input word one cycle later; enable_out_1x rises with it.
- Interrupted settle: a valid gap at cycle 10 of settling -> counter restarts; RUN entered 16 valid cycles after the gap; underflow_count stays 0.
- Underflow: in RUN, drop adc_valid_in for 1 cycle -> valid_out_1x=0 and data=0 next cycle, state_out=1, sticky=1, count=1; re-qualification takes 16 valid cycles.
- Saturation/clear: COUNT_W=2, force 5 underflows -> count=3. Then clear_status in the same cycle as an underflow -> count=1, sticky=1.
- Swap: swap_samples=1, adc_i_in=32'h2222_1111, adc_q_in=32'h4444_3333 in RUN -> adc_i_out_1x=32'h1111_2222, adc_q_out_1x=32'h3333_4444 one cycle later.
